sr_bank_ctrl: RTL and testbench
===============================

// Module: sr_bank_ctrl
// PURPOSE
//  Controller for a bank of N SR-latch status bits. Two requesters issue set/clear commands.
//  The block arbitrates between them round-robin and drives one-hot S/R pulses into the bank.
//  It guarantees the forbidden S=R=1 input is never presented to any latch.
//  It keeps a registered shadow copy of every latch state for readback.
// PARAMETERS
//  N          8   number of SR latches in the bank
//  IDX_W      3   index width; must satisfy 2**IDX_W >= N
//  PULSE_CYC  2   cycles S or R is held high per command (>=1)
//  SETTLE_CYC 1   all-zero cycles after a pulse, before done (>=1)
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      synchronous reset, active-high
//  req_a    in   1      requester A command valid; held until gnt_a
//  op_a     in   1      requester A op: 1=set, 0=clear
//  idx_a    in   IDX_W  requester A target latch index
//  gnt_a    out  1      one-cycle accept pulse to A
//  req_b    in   1      requester B command valid; held until gnt_b
//  op_b     in   1      requester B op: 1=set, 0=clear
//  idx_b    in   IDX_W  requester B target latch index
//  gnt_b    out  1      one-cycle accept pulse to B
//  s_out    out  N      set lines to latch bank
//  r_out    out  N      reset lines to latch bank
//  q_shadow out  N      shadow of latch states
//  busy     out  1      high in any state other than IDLE
//  done     out  1      one-cycle pulse when a command completes
//  err      out  1      one-cycle pulse with done when idx >= N (command dropped)
// BEHAVIOUR
//  Reset (rst=1 at an edge): all outputs 0, state IDLE, RR pointer favours A.
//  Reset mid-operation: S/R lines drop to 0 at that edge; the pending command is discarded.
//  FSM states: IDLE -> DRIVE -> SETTLE -> DONE -> IDLE.
//  IDLE: at an edge with req_a|req_b, the arbiter picks a winner.
//   - On entry to DRIVE: capture the winner's op and idx; the winner's gnt=1 for that first cycle only.
//  DRIVE, PULSE_CYC cycles:
//   - op=1: s_out[idx]=1, r_out=0.
//   - op=0: r_out[idx]=1, s_out=0.
//   - All other bits are 0.
//   - If idx >= N, s_out and r_out stay 0.
//  SETTLE, SETTLE_CYC cycles: s_out=r_out=0.
//  DONE, 1 cycle: done=1. q_shadow[idx]=op is updated on entry to DONE.
//   - If idx >= N: err=1 and q_shadow is unchanged.
//  Next edge returns to IDLE; a new req can be accepted at that IDLE edge.
//  Latency: accept edge to done=1 is PULSE_CYC+SETTLE_CYC+1 cycles.
//  Throughput: one command per PULSE_CYC+SETTLE_CYC+2 cycles.
//  Arbitration:
//   - Only one requester: it wins.
//   - Both requesting: the one not granted last wins.
//   - The pointer updates only on a grant.
//  Invariant, every cycle: (s_out & r_out) == 0, and popcount(s_out|r_out) <= 1.
//  Redundant command (set on a set bit) is still pulsed; no short-cut.
//  Requests arriving while busy are not sampled; requesters keep req high until gnt.
//  The counter is a single down-counter of width clog2(max(PULSE_CYC,SETTLE_CYC)+1).
//   - It is reloaded on each state entry.
// STRUCTURE
//  Package sr_ctrl_pkg:
//   - state encoding ST_IDLE/ST_DRIVE/ST_SETTLE/ST_DONE
//   - OP_SET=1'b1, OP_CLR=1'b0
//  Sub-module rr_arb2: two-way round-robin arbiter.
//   - Inputs req[1:0], advance; output one-hot grant[1:0]; holds a last-winner flop.
//  Top: FSM, command capture regs, down-counter, one-hot decoder, q_shadow register.
// TESTING
//  1. Reset; A set idx=3 (defaults) -> gnt_a one cycle; s_out=8'h08 for 2 cycles; 1 zero cycle;
//     done; q_shadow=8'h08.
//  2. Then B clear idx=3 -> r_out=8'h08 for 2 cycles, s_out=0 throughout; q_shadow=8'h00.
//  3. A and B both req simultaneously from reset -> A granted first, B next;
//     repeat with both held -> grants alternate A,B,A,B.
//  4. N=6, A set idx=7 -> s_out=r_out=0 all command; done with err=1; q_shadow unchanged.
//  5. rst=1 during 2nd DRIVE cycle -> next edge s_out=r_out=0, q_shadow=0, busy=0, no done.
//  6. Random 1000 commands -> (s_out & r_out)==0 every cycle; q_shadow equals reference model.

Source files
------------

// File: rtl/sr_bank_ctrl_pkg.sv
// Shared types and constants for the SR-latch bank controller.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_bank_ctrl_if.sv
// Requester handshakes plus latch-bank drive and status lines of the controller.
interface sr_bank_ctrl_if #(
   parameter int N     = 8,
   parameter int IDX_W = 3
);
   logic             req_a;
   logic             op_a;
   logic [IDX_W-1:0] idx_a;
   logic             gnt_a;
   logic             req_b;
   logic             op_b;
   logic [IDX_W-1:0] idx_b;
   logic             gnt_b;
   logic [N-1:0]     s_out;
   logic [N-1:0]     r_out;
   logic [N-1:0]     q_shadow;
   logic             busy;
   logic             done;
   logic             err;

   // Controller side
   modport slave (
      input  req_a, op_a, idx_a, req_b, op_b, idx_b,
      output gnt_a, gnt_b, s_out, r_out, q_shadow, busy, done, err
   );

   // Requester / bank side
   modport master (
      output req_a, op_a, idx_a, req_b, op_b, idx_b,
      input  gnt_a, gnt_b, s_out, r_out, q_shadow, busy, done, err
   );
endinterface

// File: rtl/sr_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // 1 when B won last, so A is favoured on a tie; reset favours A.
   logic last_b_q;

   // Grant a lone requester outright; on a tie grant the one not granted last.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_b_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Remember the last winner, only when a grant is actually taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_b_q <= 1'b1;
      end else if (advance) begin
         last_b_q <= grant[1];
      end
   end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Arbitrated set/clear pulse controller for a bank of N SR latches with shadow readback.
// S and R are registered one-hot vectors, never both non-zero, so no latch sees S=R=1.
module sr_bank_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int N          = 8,
   parameter int IDX_W      = 3,
   parameter int PULSE_CYC  = 2,
   parameter int SETTLE_CYC = 1
) (
   input logic            clk,
   input logic            rst,
   sr_bank_ctrl_if.slave  bus
);

   localparam int MAXC  = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
   localparam int CNT_W = $clog2(MAXC + 1);
   localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

   // One-hot decode; an out-of-range index decodes to all zeros.
   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [N-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) begin
         if (i == IDX_W'(k)) v[k] = 1'b1;
      end
      return v;
   endfunction

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             op_q;
   logic [IDX_W-1:0] idx_q;
   logic [N-1:0]     s_q, r_q, shadow_q;
   logic             gnt_a_q, gnt_b_q, busy_q, done_q, err_q;

   logic [1:0]       grant;
   logic             accept_d;
   logic             win_op_d;
   logic [IDX_W-1:0] win_idx_d;
   logic [N-1:0]     win_hot_d, s_d, r_d, cur_hot_d, shadow_d;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({bus.req_b, bus.req_a}),
      .advance (accept_d),
      .grant   (grant)
   );

   // Requests are only sampled in IDLE; elsewhere the arbiter output is ignored.
   assign accept_d = (state_q == ST_IDLE) && (grant != 2'b00);

   // Select the winning command and decode the S/R vectors it will drive.
   always_comb begin
      win_op_d  = bus.op_a;
      win_idx_d = bus.idx_a;
      if (grant[1]) begin
         win_op_d  = bus.op_b;
         win_idx_d = bus.idx_b;
      end
      win_hot_d = onehot(win_idx_d);
      s_d       = (win_op_d == OP_SET) ? win_hot_d : '0;
      r_d       = (win_op_d == OP_CLR) ? win_hot_d : '0;
   end

   // Shadow value after applying the captured command; unchanged for a bad index.
   always_comb begin
      cur_hot_d = onehot(idx_q);
      shadow_d  = (op_q == OP_SET) ? (shadow_q | cur_hot_d) : (shadow_q & ~cur_hot_d);
   end

   // Main FSM with registered outputs; the down-counter is reloaded on every state entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_CLR;
         idx_q    <= '0;
         s_q      <= '0;
         r_q      <= '0;
         shadow_q <= '0;
         gnt_a_q  <= 1'b0;
         gnt_b_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  state_q <= ST_DRIVE;
                  cnt_q   <= PULSE_LD;
                  op_q    <= win_op_d;
                  idx_q   <= win_idx_d;
                  s_q     <= s_d;
                  r_q     <= r_d;
                  gnt_a_q <= grant[0];
                  gnt_b_q <= grant[1];
                  busy_q  <= 1'b1;
               end
            end
            ST_DRIVE: begin
               if (cnt_q == '0) begin
                  state_q <= ST_SETTLE;
                  cnt_q   <= SETTLE_LD;
                  s_q     <= '0;
                  r_q     <= '0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q  <= ST_DONE;
                  cnt_q    <= '0;
                  done_q   <= 1'b1;
                  err_q    <= (cur_hot_d == '0);
                  shadow_q <= shadow_d;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               s_q     <= '0;
               r_q     <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt_a    = gnt_a_q;
   assign bus.gnt_b    = gnt_b_q;
   assign bus.s_out    = s_q;
   assign bus.r_out    = r_q;
   assign bus.q_shadow = shadow_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed bench for sr_bank_ctrl: an N=8 instance and an N=6 instance share clock and reset.
module tb_sr_bank_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mon_en = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sr_bank_ctrl_if #(.N(8), .IDX_W(3)) bus8 ();
   sr_bank_ctrl_if #(.N(6), .IDX_W(3)) bus6 ();

   sr_bank_ctrl #(.N(8), .IDX_W(3), .PULSE_CYC(2), .SETTLE_CYC(1)) dut8 (
      .clk (clk), .rst (rst), .bus (bus8)
   );
   sr_bank_ctrl #(.N(6), .IDX_W(3), .PULSE_CYC(2), .SETTLE_CYC(1)) dut6 (
      .clk (clk), .rst (rst), .bus (bus6)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for the next grant pulse on the N=8 instance.
   task automatic next_grant(output logic [1:0] g);
      g = 2'b00;
      for (int k = 0; k < 20 && g == 2'b00; k++) begin
         step();
         g = {bus8.gnt_b, bus8.gnt_a};
      end
   endtask

   task automatic wait_idle8();
      for (int k = 0; k < 20 && bus8.busy; k++) step();
   endtask

   // Latch-input safety on both instances, every cycle after the first reset.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("inv_and8", 32'(bus8.s_out & bus8.r_out), 0);
         chk("inv_pop8", 32'($countones(bus8.s_out | bus8.r_out) <= 1), 1);
         chk("inv_and6", 32'(bus6.s_out & bus6.r_out), 0);
         chk("inv_pop6", 32'($countones(bus6.s_out | bus6.r_out) <= 1), 1);
      end
   end

   initial begin
      logic [1:0] g;
      logic [7:0] model;
      int grants;
      int cyc;

      bus8.req_a = 0; bus8.op_a = 0; bus8.idx_a = 0;
      bus8.req_b = 0; bus8.op_b = 0; bus8.idx_b = 0;
      bus6.req_a = 0; bus6.op_a = 0; bus6.idx_a = 0;
      bus6.req_b = 0; bus6.op_b = 0; bus6.idx_b = 0;

      // Reset state
      rst = 1;
      step(); step();
      chk("rst_s", 32'(bus8.s_out), 0);
      chk("rst_r", 32'(bus8.r_out), 0);
      chk("rst_q", 32'(bus8.q_shadow), 0);
      chk("rst_busy", 32'(bus8.busy), 0);
      chk("rst_done", 32'(bus8.done), 0);
      chk("rst_gnt", 32'({bus8.gnt_b, bus8.gnt_a}), 0);
      chk("rst_q6", 32'(bus6.q_shadow), 0);
      mon_en = 1;
      rst = 0;
      step();

      // 1: A sets bit 3
      bus8.req_a = 1; bus8.op_a = 1; bus8.idx_a = 3;
      step();
      chk("t1_gnt_a", 32'(bus8.gnt_a), 1);
      chk("t1_s_c1", 32'(bus8.s_out), 32'h08);
      chk("t1_r_c1", 32'(bus8.r_out), 0);
      chk("t1_busy", 32'(bus8.busy), 1);
      bus8.req_a = 0;
      step();
      chk("t1_gnt_a_c2", 32'(bus8.gnt_a), 0);
      chk("t1_s_c2", 32'(bus8.s_out), 32'h08);
      step();
      chk("t1_s_settle", 32'(bus8.s_out), 0);
      chk("t1_done_early", 32'(bus8.done), 0);
      step();
      chk("t1_done", 32'(bus8.done), 1);
      chk("t1_err", 32'(bus8.err), 0);
      chk("t1_q", 32'(bus8.q_shadow), 32'h08);
      step();
      chk("t1_done_off", 32'(bus8.done), 0);
      chk("t1_idle", 32'(bus8.busy), 0);

      // 2: B clears bit 3
      bus8.req_b = 1; bus8.op_b = 0; bus8.idx_b = 3;
      step();
      chk("t2_gnt_b", 32'(bus8.gnt_b), 1);
      chk("t2_gnt_a", 32'(bus8.gnt_a), 0);
      chk("t2_r_c1", 32'(bus8.r_out), 32'h08);
      chk("t2_s_c1", 32'(bus8.s_out), 0);
      bus8.req_b = 0;
      step();
      chk("t2_r_c2", 32'(bus8.r_out), 32'h08);
      chk("t2_s_c2", 32'(bus8.s_out), 0);
      step();
      chk("t2_r_settle", 32'(bus8.r_out), 0);
      step();
      chk("t2_done", 32'(bus8.done), 1);
      chk("t2_q", 32'(bus8.q_shadow), 0);
      step();

      // 3: simultaneous requests from reset, both held -> A,B,A,B
      rst = 1;
      step();
      rst = 0;
      bus8.req_a = 1; bus8.op_a = 1; bus8.idx_a = 6;
      bus8.req_b = 1; bus8.op_b = 0; bus8.idx_b = 6;
      next_grant(g); chk("t3_g1", 32'(g), 32'b01);
      next_grant(g); chk("t3_g2", 32'(g), 32'b10);
      next_grant(g); chk("t3_g3", 32'(g), 32'b01);
      next_grant(g); chk("t3_g4", 32'(g), 32'b10);
      bus8.req_a = 0; bus8.req_b = 0;
      wait_idle8();
      chk("t3_idle", 32'(bus8.busy), 0);
      chk("t3_q", 32'(bus8.q_shadow), 0);

      // 4: N=6, valid set of bit 2, then out-of-range idx 7
      bus6.req_a = 1; bus6.op_a = 1; bus6.idx_a = 2;
      step();
      chk("t4_gnt_ok", 32'(bus6.gnt_a), 1);
      chk("t4_s_ok", 32'(bus6.s_out), 32'h04);
      bus6.req_a = 0;
      step(); step(); step();
      chk("t4_done_ok", 32'(bus6.done), 1);
      chk("t4_q_ok", 32'(bus6.q_shadow), 32'h04);
      step();
      bus6.req_a = 1; bus6.op_a = 1; bus6.idx_a = 7;
      step();
      chk("t4_gnt_bad", 32'(bus6.gnt_a), 1);
      chk("t4_s_c1", 32'(bus6.s_out), 0);
      chk("t4_r_c1", 32'(bus6.r_out), 0);
      bus6.req_a = 0;
      step();
      chk("t4_s_c2", 32'(bus6.s_out), 0);
      chk("t4_r_c2", 32'(bus6.r_out), 0);
      step();
      step();
      chk("t4_done_bad", 32'(bus6.done), 1);
      chk("t4_err", 32'(bus6.err), 1);
      chk("t4_q_kept", 32'(bus6.q_shadow), 32'h04);
      step();
      chk("t4_err_off", 32'(bus6.err), 0);

      // 5: reset during the second DRIVE cycle
      bus8.req_a = 1; bus8.op_a = 1; bus8.idx_a = 5;
      step();
      bus8.req_a = 0;
      step(); step(); step();
      chk("t5_q_pre", 32'(bus8.q_shadow), 32'h20);
      step();
      bus8.req_a = 1; bus8.op_a = 1; bus8.idx_a = 1;
      step();
      chk("t5_gnt", 32'(bus8.gnt_a), 1);
      bus8.req_a = 0;
      step();
      chk("t5_s_c2", 32'(bus8.s_out), 32'h02);
      rst = 1;
      step();
      chk("t5_s", 32'(bus8.s_out), 0);
      chk("t5_r", 32'(bus8.r_out), 0);
      chk("t5_q", 32'(bus8.q_shadow), 0);
      chk("t5_busy", 32'(bus8.busy), 0);
      chk("t5_done", 32'(bus8.done), 0);
      rst = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t5_no_done", 32'(bus8.done), 0);
      end

      // 6: 1000 random commands against a shadow model
      model = 8'h00;
      grants = 0;
      cyc = 0;
      while (grants < 1000 && cyc < 20000) begin
         if (!bus8.req_a && $urandom_range(0, 1) == 1) begin
            bus8.req_a = 1;
            bus8.op_a  = 1'($urandom_range(0, 1));
            bus8.idx_a = 3'($urandom_range(0, 7));
         end
         if (!bus8.req_b && $urandom_range(0, 1) == 1) begin
            bus8.req_b = 1;
            bus8.op_b  = 1'($urandom_range(0, 1));
            bus8.idx_b = 3'($urandom_range(0, 7));
         end
         step();
         cyc++;
         if (bus8.done) begin
            chk("t6_q", 32'(bus8.q_shadow), 32'(model));
            chk("t6_err", 32'(bus8.err), 0);
         end
         if (bus8.gnt_a) begin
            model[bus8.idx_a] = bus8.op_a;
            bus8.req_a = 0;
            grants++;
         end
         if (bus8.gnt_b) begin
            model[bus8.idx_b] = bus8.op_b;
            bus8.req_b = 0;
            grants++;
         end
      end
      chk("t6_count", 32'(grants), 1000);
      bus8.req_a = 0; bus8.req_b = 0;
      wait_idle8();
      chk("t6_q_final", 32'(bus8.q_shadow), 32'(model));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
